// File: rtl/interrupt_pkg.sv
// Shared types and defaults for the prioritised interrupt controller.
// Optional internal timer source is enabled with IRQ_TIMER_EN.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        ISR  = 2'd2,
        RET  = 2'd3
    } state_t;

    typedef struct packed {
        logic int_take;
        logic ret_sel;
        logic in_isr;
    } ctl_out_t;

    localparam logic [7:0] VECTOR_BASE   = 8'h70;
    localparam logic [7:0] VECTOR_STRIDE = 8'h10;
    localparam logic [7:0] TIMER_PERIOD  = 8'd10;

    // Vector address wraps modulo 256.
    function automatic logic [7:0] vec_addr(input logic [2:0] id,
                                            input logic [7:0] base,
                                            input logic [7:0] stride);
        logic [7:0] offs;
        offs = {5'd0, id} * stride;
        return base + offs;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: lowest set index wins.
module irq_priority_encoder #(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0] eligible,
    output logic             valid,
    output logic [2:0]       id
);

    always_comb begin
        valid = |eligible;
        id    = 3'd0;
        // Scan downward so the lowest asserted index is written last.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Non-nesting prioritised interrupt controller for program_sequencer.
// Define IRQ_TIMER_EN to add a periodic internal request on source 0.
module interrupt_controller #(
    parameter int         N_IRQ         = 4,
    parameter logic [7:0] VECTOR_BASE   = interrupt_pkg::VECTOR_BASE,
    parameter logic [7:0] VECTOR_STRIDE = interrupt_pkg::VECTOR_STRIDE
`ifdef IRQ_TIMER_EN
    ,
    parameter logic [7:0] TIMER_PERIOD  = interrupt_pkg::TIMER_PERIOD
`endif
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_data,
    input  logic [7:0]       pc,
    input  logic             reti,
    output logic             int_take,
    output logic [7:0]       vector_addr,
    output logic             ret_sel,
    output logic [7:0]       return_addr,
    output logic             in_isr,
    output logic [N_IRQ-1:0] pending
);

    import interrupt_pkg::*;

    state_t           state, state_nx;
    ctl_out_t         ctl;
    logic             take_now;
    logic [N_IRQ-1:0] req_d;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] set_bits;
    logic [N_IRQ-1:0] clr_bits;
    logic [N_IRQ-1:0] eligible;
    logic             win_valid;
    logic [2:0]       win_id;
    logic             timer_tick;

`ifdef IRQ_TIMER_EN
    logic [7:0] tmr;

    always_ff @(posedge clk) begin
        if (!sync_reset_n)     tmr <= TIMER_PERIOD;
        else if (tmr == 8'd0)  tmr <= TIMER_PERIOD;
        else                   tmr <= tmr - 8'd1;
    end

    assign timer_tick = (tmr == 8'd0);
`else
    assign timer_tick = 1'b0;
`endif

    assign rise     = irq_req & ~req_d;
    assign eligible = pending & ~mask;

    always_comb begin
        set_bits    = rise;
        set_bits[0] = rise[0] | timer_tick;
    end

    irq_priority_encoder #(.N_IRQ(N_IRQ)) u_prio (
        .eligible (eligible),
        .valid    (win_valid),
        .id       (win_id)
    );

    always_comb begin
        state_nx = state;
        ctl      = '0;
        take_now = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nx = TAKE;
                    take_now = 1'b1;
                end
            end
            TAKE: begin
                ctl.int_take = 1'b1;
                state_nx     = ISR;
            end
            ISR: begin
                ctl.in_isr = 1'b1;
                if (reti) state_nx = RET;
            end
            RET: begin
                ctl.ret_sel = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        clr_bits = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_bits[i] = take_now && (win_id == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) state <= IDLE;
        else               state <= state_nx;
    end

    // Set is applied after clear so a fresh edge on the winner is not lost.
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            req_d       <= '0;
            pending     <= '0;
            mask        <= '0;
            vector_addr <= 8'd0;
            return_addr <= 8'd0;
        end else begin
            req_d   <= irq_req;
            pending <= (pending & ~clr_bits) | set_bits;
            if (mask_wr)       mask        <= mask_data;
            if (take_now)      vector_addr <= vec_addr(win_id, VECTOR_BASE, VECTOR_STRIDE);
            if (state == TAKE) return_addr <= pc + 8'd1;
        end
    end

    assign int_take = ctl.int_take;
    assign ret_sel  = ctl.ret_sel;
    assign in_isr   = ctl.in_isr;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-cycle vector table plus
// hand-written reset-in-ISR and (with IRQ_TIMER_EN) timer-period sequences.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       sync_reset_n;
    logic [3:0] irq_req;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic [7:0] pc;
    logic       reti;
    logic       int_take;
    logic [7:0] vector_addr;
    logic       ret_sel;
    logic [7:0] return_addr;
    logic       in_isr;
    logic [3:0] pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .irq_req      (irq_req),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .pc           (pc),
        .reti         (reti),
        .int_take     (int_take),
        .vector_addr  (vector_addr),
        .ret_sel      (ret_sel),
        .return_addr  (return_addr),
        .in_isr       (in_isr),
        .pending      (pending)
    );

    typedef struct {
        logic [3:0] irq;
        logic       mw;
        logic [3:0] md;
        logic [7:0] pc;
        logic       reti;
        logic       tk;
        logic       rs;
        logic       isr;
        logic [3:0] pd;
        logic [7:0] va;
        logic [7:0] ra;
    } vec_t;

    localparam int NV = 40;
    vec_t tbl [NV];

    function automatic vec_t mk(logic [3:0] irq, logic mw, logic [3:0] md, logic [7:0] p,
                                logic rt, logic tk, logic rs, logic isr, logic [3:0] pd,
                                logic [7:0] va, logic [7:0] ra);
        vec_t v;
        v.irq = irq; v.mw = mw; v.md = md; v.pc = p; v.reti = rt;
        v.tk = tk; v.rs = rs; v.isr = isr; v.pd = pd; v.va = va; v.ra = ra;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse-shape invariant checked every cycle.
    logic prev_tk = 1'b0, prev_rs = 1'b0;
    always @(negedge clk) begin
        checks++;
        if ((int_take && ret_sel) || (int_take && prev_tk) || (ret_sel && prev_rs)) begin
            errors++;
            $display("FAIL pulse_shape: take=%0b ret_sel=%0b prev_take=%0b prev_ret=%0b",
                     int_take, ret_sel, prev_tk, prev_rs);
        end
        prev_tk = int_take;
        prev_rs = ret_sel;
    end

    initial begin
        sync_reset_n = 1'b0;
        irq_req = 4'b0; mask_wr = 1'b0; mask_data = 4'b0; pc = 8'h00; reti = 1'b0;
        repeat (3) step();
        chk("rst_take", {31'd0, int_take}, 0);
        chk("rst_ret_sel", {31'd0, ret_sel}, 0);
        chk("rst_in_isr", {31'd0, in_isr}, 0);
        chk("rst_pending", {28'd0, pending}, 0);
        chk("rst_vector", {24'd0, vector_addr}, 0);
        chk("rst_return", {24'd0, return_addr}, 0);
        sync_reset_n = 1'b1;

`ifndef IRQ_TIMER_EN
        //             irq     mw  md      pc     rt | tk rs isr pd       va     ra
        tbl[0]  = mk(4'b0000,0,4'b0000,8'h00,0, 0,0,0,4'b0000,8'h00,8'h00);
        tbl[1]  = mk(4'b0100,0,4'b0000,8'h00,0, 0,0,0,4'b0100,8'h00,8'h00);
        tbl[2]  = mk(4'b0100,0,4'b0000,8'h00,0, 1,0,0,4'b0000,8'h90,8'h00);
        tbl[3]  = mk(4'b0100,0,4'b0000,8'h23,0, 0,0,1,4'b0000,8'h90,8'h24);
        tbl[4]  = mk(4'b0100,0,4'b0000,8'h00,1, 0,1,0,4'b0000,8'h90,8'h24);
        tbl[5]  = mk(4'b0100,0,4'b0000,8'h00,0, 0,0,0,4'b0000,8'h90,8'h24);
        tbl[6]  = mk(4'b1110,0,4'b0000,8'h00,0, 0,0,0,4'b1010,8'h90,8'h24);
        tbl[7]  = mk(4'b1110,0,4'b0000,8'h00,0, 1,0,0,4'b1000,8'h80,8'h24);
        tbl[8]  = mk(4'b1110,0,4'b0000,8'h40,0, 0,0,1,4'b1000,8'h80,8'h41);
        tbl[9]  = mk(4'b1110,0,4'b0000,8'h00,1, 0,1,0,4'b1000,8'h80,8'h41);
        tbl[10] = mk(4'b1110,0,4'b0000,8'h00,0, 0,0,0,4'b1000,8'h80,8'h41);
        tbl[11] = mk(4'b1110,0,4'b0000,8'h00,0, 1,0,0,4'b0000,8'hA0,8'h41);
        tbl[12] = mk(4'b1110,0,4'b0000,8'hFF,0, 0,0,1,4'b0000,8'hA0,8'h00);
        tbl[13] = mk(4'b1110,0,4'b0000,8'h00,1, 0,1,0,4'b0000,8'hA0,8'h00);
        tbl[14] = mk(4'b0000,0,4'b0000,8'h00,0, 0,0,0,4'b0000,8'hA0,8'h00);
        tbl[15] = mk(4'b0000,0,4'b0000,8'h00,1, 0,0,0,4'b0000,8'hA0,8'h00);
        tbl[16] = mk(4'b0000,1,4'b0001,8'h00,0, 0,0,0,4'b0000,8'hA0,8'h00);
        tbl[17] = mk(4'b0001,0,4'b0000,8'h00,0, 0,0,0,4'b0001,8'hA0,8'h00);
        tbl[18] = mk(4'b0001,0,4'b0000,8'h00,0, 0,0,0,4'b0001,8'hA0,8'h00);
        tbl[19] = mk(4'b0001,0,4'b0000,8'h00,0, 0,0,0,4'b0001,8'hA0,8'h00);
        tbl[20] = mk(4'b0001,1,4'b0000,8'h00,0, 0,0,0,4'b0001,8'hA0,8'h00);
        tbl[21] = mk(4'b0001,0,4'b0000,8'h00,0, 1,0,0,4'b0000,8'h70,8'h00);
        tbl[22] = mk(4'b0001,0,4'b0000,8'h10,0, 0,0,1,4'b0000,8'h70,8'h11);
        tbl[23] = mk(4'b0011,0,4'b0000,8'h00,0, 0,0,1,4'b0010,8'h70,8'h11);
        tbl[24] = mk(4'b0011,0,4'b0000,8'h00,1, 0,1,0,4'b0010,8'h70,8'h11);
        tbl[25] = mk(4'b0011,0,4'b0000,8'h00,0, 0,0,0,4'b0010,8'h70,8'h11);
        tbl[26] = mk(4'b0011,0,4'b0000,8'h00,0, 1,0,0,4'b0000,8'h80,8'h11);
        tbl[27] = mk(4'b0011,0,4'b0000,8'h55,0, 0,0,1,4'b0000,8'h80,8'h56);
        tbl[28] = mk(4'b0011,0,4'b0000,8'h00,1, 0,1,0,4'b0000,8'h80,8'h56);
        tbl[29] = mk(4'b0000,0,4'b0000,8'h00,0, 0,0,0,4'b0000,8'h80,8'h56);
        tbl[30] = mk(4'b0000,1,4'b0100,8'h00,0, 0,0,0,4'b0000,8'h80,8'h56);
        tbl[31] = mk(4'b0100,0,4'b0000,8'h00,0, 0,0,0,4'b0100,8'h80,8'h56);
        tbl[32] = mk(4'b0000,0,4'b0000,8'h00,0, 0,0,0,4'b0100,8'h80,8'h56);
        tbl[33] = mk(4'b0000,1,4'b0000,8'h00,0, 0,0,0,4'b0100,8'h80,8'h56);
        tbl[34] = mk(4'b0100,0,4'b0000,8'h00,0, 1,0,0,4'b0100,8'h90,8'h56);
        tbl[35] = mk(4'b0100,0,4'b0000,8'h00,0, 0,0,1,4'b0100,8'h90,8'h01);
        tbl[36] = mk(4'b0100,0,4'b0000,8'h00,1, 0,1,0,4'b0100,8'h90,8'h01);
        tbl[37] = mk(4'b0100,0,4'b0000,8'h00,0, 0,0,0,4'b0100,8'h90,8'h01);
        tbl[38] = mk(4'b0100,0,4'b0000,8'h00,0, 1,0,0,4'b0000,8'h90,8'h01);
        tbl[39] = mk(4'b0110,0,4'b0000,8'h00,0, 0,0,1,4'b0010,8'h90,8'h01);

        for (int r = 0; r < NV; r++) begin
            irq_req = tbl[r].irq; mask_wr = tbl[r].mw; mask_data = tbl[r].md;
            pc = tbl[r].pc; reti = tbl[r].reti;
            step();
            chk($sformatf("row%0d_take", r), {31'd0, int_take}, {31'd0, tbl[r].tk});
            chk($sformatf("row%0d_ret_sel", r), {31'd0, ret_sel}, {31'd0, tbl[r].rs});
            chk($sformatf("row%0d_in_isr", r), {31'd0, in_isr}, {31'd0, tbl[r].isr});
            chk($sformatf("row%0d_pending", r), {28'd0, pending}, {28'd0, tbl[r].pd});
            chk($sformatf("row%0d_vector", r), {24'd0, vector_addr}, {24'd0, tbl[r].va});
            chk($sformatf("row%0d_return", r), {24'd0, return_addr}, {24'd0, tbl[r].ra});
        end

        // Reset while in ISR with a request pending.
        irq_req = 4'b0000; mask_wr = 1'b0; reti = 1'b0; pc = 8'h00;
        sync_reset_n = 1'b0;
        step();
        chk("isr_rst_in_isr", {31'd0, in_isr}, 0);
        chk("isr_rst_ret_sel", {31'd0, ret_sel}, 0);
        chk("isr_rst_pending", {28'd0, pending}, 0);
        chk("isr_rst_vector", {24'd0, vector_addr}, 0);
        sync_reset_n = 1'b1;
        step();
        chk("post_rst_ret_sel", {31'd0, ret_sel}, 0);
        chk("post_rst_take", {31'd0, int_take}, 0);
        irq_req = 4'b0001;
        step();
        chk("post_rst_pending", {28'd0, pending}, 4'b0001);
        chk("post_rst_early_take", {31'd0, int_take}, 0);
        step();
        chk("post_rst_take2", {31'd0, int_take}, 1);
        chk("post_rst_vector", {24'd0, vector_addr}, 8'h70);
        begin
            int n = 0;
            while (!in_isr && n < 8) begin step(); n++; end
            if (!in_isr) begin
                checks++; errors++;
                $display("FAIL post_rst_isr_timeout: in_isr=%0b expected 1", in_isr);
            end
        end
        reti = 1'b1;
        step();
        reti = 1'b0;
        chk("post_rst_ret_sel2", {31'd0, ret_sel}, 1);
`else
        // Timer-only: take recurs every TIMER_PERIOD+1 cycles.
        begin
            int cyc = 0;
            int last = -1;
            int reti_at = -1;
            int seen = 0;
            while (seen < 5 && cyc < 300) begin
                reti = (cyc == reti_at);
                step();
                cyc++;
                if (int_take) begin
                    chk($sformatf("tmr_vector%0d", seen), {24'd0, vector_addr}, 8'h70);
                    if (last >= 0) chk($sformatf("tmr_period%0d", seen), cyc - last, 11);
                    last = cyc;
                    reti_at = cyc + 2;
                    seen++;
                end
            end
            reti = 1'b0;
            if (seen < 5) begin
                checks++; errors++;
                $display("FAIL tmr_timeout: takes seen %0d expected 5", seen);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Prioritised interrupt controller that sits beside program_sequencer and schedules its interrupt entry and return. It collects N edge-triggered requests, masks them, and picks the highest-priority pending source. It hands the sequencer a one-cycle take pulse, a vector address, a saved return address and a return-select pulse. Only one ISR is active at a time; there is no nesting.

Parameters:
N_IRQ, 4, number of request lines (1..8)
VECTOR_BASE, 8'h70, program-memory address of the source-0 vector
VECTOR_STRIDE, 8'h10, address spacing between consecutive vectors
TIMER_PERIOD, 8'd10, reload value of the optional internal timer

Ports:
clk  in  1  system clock; all state updates on posedge
sync_reset_n  in  1  synchronous reset, active-low
irq_req  in  N_IRQ  level request lines; a rising edge requests service
mask_wr  in  1  write strobe for the mask register
mask_data  in  N_IRQ  new mask value; 1 = source disabled
pc  in  8  sequencer's current pc
reti  in  1  one-cycle pulse: ISR has executed its return instruction
int_take  out  1  one-cycle pulse: sequencer loads vector_addr into pm_addr
vector_addr  out  8  vector address of the source being taken
ret_sel  out  1  one-cycle pulse: sequencer loads return_addr into pm_addr
return_addr  out  8  saved return address
in_isr  out  1  high while an ISR is active
pending  out  N_IRQ  latched pending bits

Behaviour:
- Reset (sync_reset_n=0 at posedge):
  - State = IDLE.
  - pending, mask, the irq_req edge-detect register, return_addr and vector_addr are 0.
  - int_take, ret_sel and in_isr are 0.
  - Reset mid-ISR abandons the ISR with no ret_sel pulse.
- Edge detect: req_d <= irq_req every cycle. rise = irq_req & ~req_d. pending[i] is set on rise[i].
- Eligible = pending & ~mask. Lowest index has highest priority. The winner id comes from the priority encoder.
- FSM states: IDLE, TAKE, ISR, RET.
  - IDLE: if eligible != 0, go to TAKE.
    - At that edge: latch id, set vector_addr = VECTOR_BASE + id*VECTOR_STRIDE (mod 256), clear pending[id].
  - TAKE (1 cycle): int_take=1, then go to ISR.
    - At that edge: return_addr <= pc + 1 (mod 256).
  - ISR: in_isr=1. When reti=1, go to RET. reti in any other state is ignored.
  - RET (1 cycle): ret_sel=1, then go to IDLE.
    - A source still eligible is taken next from IDLE, so the earliest re-entry is 2 cycles after ret_sel.
- Latency: rising edge of irq_req seen at edge k → pending at k+1 → int_take high in cycle k+2, provided the FSM was IDLE and the source is unmasked.
- Simultaneous events:
  - A rise on the source being cleared in the same cycle: set wins, pending stays 1.
  - mask_wr takes effect at the next edge. Masking does not clear pending; unmasking later gets it serviced.
  - Requests during TAKE/ISR/RET stay pending.
- int_take and ret_sel are never high together, and never high for two consecutive cycles.

Optional Feature:
IRQ_TIMER_EN.
- Defined: adds an 8-bit down-counter.
  - Loads TIMER_PERIOD on reset.
  - Decrements each cycle and reloads TIMER_PERIOD when it reaches 0.
  - The cycle it reads 0 sets pending[0], ORed with rise[0].
  - Resulting period: TIMER_PERIOD+1 cycles.
- Undefined: no counter; pending[0] is driven only by irq_req[0].

Decomposition:
- Package interrupt_pkg holds:
  - state enum (IDLE, TAKE, ISR, RET)
  - default constants VECTOR_BASE, VECTOR_STRIDE, TIMER_PERIOD
  - vector-address function (base + id*stride)
- One sub-module: irq_priority_encoder (N_IRQ-bit eligible vector in; valid and 3-bit id out; purely combinational).

Test Plan:
- Reset, then irq_req[2] rises at cycle 5 with pc=8'h23 during TAKE → int_take in cycle 7, vector_addr=8'h90, return_addr=8'h24, pending[2]=0.
- irq_req[1] and irq_req[3] rise in the same cycle → source 1 taken (8'h80); after reti → ret_sel one cycle, then source 3 taken (8'hA0).
- Mask=4'b0001, irq_req[0] rises → no int_take and pending[0]=1; write mask=0 → int_take, vector 8'h70.
- pc=8'hFF at TAKE → return_addr=8'h00 (wrap). reti pulsed while IDLE → no ret_sel.
- Drive sync_reset_n=0 while in ISR → next cycle in_isr=0, pending=0, no ret_sel, and a new request is serviced normally.
- IRQ_TIMER_EN defined, TIMER_PERIOD=10, no external requests, reti issued 2 cycles after each int_take → int_take with vector 8'h70 recurs every 11 cycles.
